// File: rtl/multi_blinky_if.sv
// Configuration write port and LED status bundle for multi_blinky.
interface multi_blinky_if #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned CNT_W    = 16
);
    logic                cfg_we;
    logic [7:0]          cfg_ch;
    logic [1:0]          cfg_mode;
    logic [CNT_W-1:0]    cfg_half_period;
    logic [NUM_LEDS-1:0] led;
    logic [NUM_LEDS-1:0] busy;
    logic                tick;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_half_period,
        input  led, busy, tick
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_half_period,
        output led, busy, tick
    );
endinterface

// File: rtl/multi_blinky.sv
// Multi-channel LED driver: shared tick prescaler, per-channel OFF/ON/BLINK/FLASH.
module multi_blinky #(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned TICK_HZ     = 1_000,
    parameter int unsigned NUM_LEDS    = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    multi_blinky_if.slave  bus
);
    localparam int unsigned DIV  = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FLASH = 2'd3
    } mode_e;

    logic [PS_W-1:0]     ps_q, ps_d;
    logic                tick_q, tick_d;
    mode_e               mode_q [NUM_LEDS];
    mode_e               mode_d [NUM_LEDS];
    logic [CNT_W-1:0]    hp_q   [NUM_LEDS];
    logic [CNT_W-1:0]    hp_d   [NUM_LEDS];
    logic [CNT_W-1:0]    cnt_q  [NUM_LEDS];
    logic [CNT_W-1:0]    cnt_d  [NUM_LEDS];
    logic [CNT_W-1:0]    hpe_m1 [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] busy_q, busy_d;

    // State registers for prescaler and all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
            led_q  <= '0;
            busy_q <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= MODE_OFF;
                hp_q[i]   <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            ps_q   <= ps_d;
            tick_q <= tick_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= mode_d[i];
                hp_q[i]   <= hp_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Prescaler wraps at DIV-1; tick is high while the count sits at DIV-1.
    always_comb begin
        ps_d   = (ps_q == PS_W'(DIV - 1)) ? '0 : ps_q + PS_W'(1);
        tick_d = (ps_d == PS_W'(DIV - 1));
    end

    // Terminal count per channel: a half-period of 0 behaves as 1.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            hpe_m1[i] = (hp_q[i] == '0) ? '0 : hp_q[i] - CNT_W'(1);
        end
    end

    // Channel next-state: a write to a channel overrides that channel's tick.
    always_comb begin
        led_d  = led_q;
        busy_d = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            mode_d[i] = mode_q[i];
            hp_d[i]   = hp_q[i];
            cnt_d[i]  = cnt_q[i];
            if (bus.cfg_we && (bus.cfg_ch == 8'(i))) begin
                mode_d[i] = mode_e'(bus.cfg_mode);
                hp_d[i]   = bus.cfg_half_period;
                cnt_d[i]  = '0;
                led_d[i]  = (bus.cfg_mode != 2'(MODE_OFF));
            end else if (tick_q) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_q[i] == hpe_m1[i]) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_FLASH: begin
                        if (cnt_q[i] == hpe_m1[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            mode_d[i] = MODE_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: cnt_d[i] = '0;
                endcase
            end
            busy_d[i] = (mode_d[i] == MODE_FLASH);
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_multi_blinky.sv
// Bench for multi_blinky: directed scenarios plus random writes vs a time-based model.
module tb_multi_blinky;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 16;
    localparam int DIVT = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multi_blinky_if #(.NUM_LEDS(N), .CNT_W(CW)) bus ();

    multi_blinky #(
        .CLK_FREQ_HZ(10_000),
        .TICK_HZ    (1_000),
        .NUM_LEDS   (N),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Model: elapsed edges since reset, and ticks seen by each channel since its last write.
    int edge_cnt = 0;
    int m_mode  [N];
    int m_hpe   [N];
    int m_ticks [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt = 0;
            for (int i = 0; i < N; i++) begin
                m_mode[i] = 0; m_hpe[i] = 1; m_ticks[i] = 0;
            end
        end else begin
            bit t_pre;
            t_pre = (edge_cnt % DIVT == DIVT - 1);
            for (int i = 0; i < N; i++) begin
                if (bus.cfg_we && (int'(bus.cfg_ch) == i)) begin
                    m_mode[i]  = int'(bus.cfg_mode);
                    m_hpe[i]   = (bus.cfg_half_period == 0) ? 1 : int'(bus.cfg_half_period);
                    m_ticks[i] = 0;
                end else if (t_pre) begin
                    m_ticks[i]++;
                end
            end
            edge_cnt++;
        end
    end

    function automatic logic exp_led(int i);
        case (m_mode[i])
            1:       return 1'b1;
            2:       return ((m_ticks[i] / m_hpe[i]) % 2) == 0;
            3:       return m_ticks[i] < m_hpe[i];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_busy(int i);
        return (m_mode[i] == 3) && (m_ticks[i] < m_hpe[i]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(posedge clk) begin
        logic [N-1:0] el, eb;
        #2;
        for (int i = 0; i < N; i++) begin
            el[i] = exp_led(i);
            eb[i] = exp_busy(i);
        end
        chk("tick", 32'(bus.tick), 32'(edge_cnt % DIVT == DIVT - 1));
        chk("led",  32'(bus.led),  32'(el));
        chk("busy", 32'(bus.busy), 32'(eb));
    end

    task automatic wr(input int ch, input int mode, input int hp);
        bus.cfg_we          = 1'b1;
        bus.cfg_ch          = 8'(ch);
        bus.cfg_mode        = 2'(mode);
        bus.cfg_half_period = 16'(hp);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        for (int k = 0; k < 30; k++) begin
            if (bus.tick) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Ticks pending at each negedge until led[ch] reaches lv.
    task automatic ticks_until(input int ch, input logic lv, output int nt);
        nt = 0;
        for (int k = 0; k < 3000; k++) begin
            if (bus.led[ch] == lv) return;
            if (bus.tick) nt++;
            @(negedge clk);
        end
        nt = -1;
    endtask

    // Cycles for which led[ch] stays at lv.
    task automatic cycles_while(input int ch, input logic lv, output int n);
        n = 0;
        while (bus.led[ch] == lv && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, a, b;
        rst_n = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = '0; bus.cfg_half_period = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, tick spacing and width.
        repeat (200) @(negedge clk);
        chk("idle_led",  32'(bus.led),  32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        wait_tick("t1");
        @(negedge clk);
        chk("tick_width", 32'(bus.tick), 32'd0);
        n = 1;
        while (!bus.tick && n < 30) begin @(negedge clk); n++; end
        chk("tick_period", 32'(n), 32'd10);

        // BLINK hp=5 on ch0.
        wr(0, 2, 5);
        chk("blink_start", 32'(bus.led[0]), 32'd1);
        ticks_until(0, 1'b0, n);
        chk("blink_first_toggle_ticks", 32'(n), 32'd5);
        cycles_while(0, 1'b0, a);
        cycles_while(0, 1'b1, b);
        chk("blink_low_clks",  32'(a), 32'd50);
        chk("blink_high_clks", 32'(b), 32'd50);

        // FLASH hp=3 on ch2.
        wr(2, 3, 3);
        chk("flash_led",  32'(bus.led[2]),  32'd1);
        chk("flash_busy", 32'(bus.busy[2]), 32'd1);
        ticks_until(2, 1'b0, n);
        chk("flash_ticks", 32'(n), 32'd3);
        chk("flash_busy_fall", 32'(bus.busy[2]), 32'd0);
        repeat (500) @(negedge clk);
        chk("flash_stays_off", 32'({bus.led[2], bus.busy[2]}), 32'd0);

        // ON, BLINK hp=0, and an out-of-range write.
        wr(1, 1, 0);
        wr(3, 2, 0);
        wr(7, 1, 9);
        chk("on_led1", 32'(bus.led[1]), 32'd1);
        cycles_while(3, 1'b1, n);
        cycles_while(3, 1'b0, a);
        cycles_while(3, 1'b1, b);
        chk("hp0_low_clks",  32'(a), 32'd10);
        chk("hp0_high_clks", 32'(b), 32'd10);

        // Write coinciding with a tick loses that tick.
        wait_tick("t5");
        wr(0, 2, 2);
        ticks_until(0, 1'b0, n);
        chk("write_tick_collision_ticks", 32'(n), 32'd2);

        // Async reset mid-flash.
        wr(2, 3, 100);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_led",  32'(bus.led),  32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_led",  32'(bus.led),  32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // Random writes, checked every cycle by the model.
        for (int r = 0; r < 300; r++) begin
            int ch, md, hp, sel;
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) wait_tick("tr");
            ch  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 255) : $urandom_range(0, N - 1);
            md  = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            hp  = (sel == 0) ? 65535 : (sel < 5) ? $urandom_range(0, 3) : $urandom_range(0, 12);
            wr(ch, md, hp);
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
